// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer: multi-cycle LDM/STM block-transfer controller.
// Walks the latched register list lowest-bit first, issues one memory strobe
// per register with a MOC handshake, writes loaded data back to the register
// file and optionally updates the base register.
// Every transfer is followed by one cycle with the strobe low: after a store
// that cycle is a gap phase inside XFER, and after a load it is the LOADWR
// cycle followed by the same gap phase.
// All outputs are decoded from registered state only, so they do not depend
// combinationally on any input.
module ldm_stm_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int WORD_BYTES = 4
) (
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic                  start,
    input  logic                  L,
    input  logic                  P,
    input  logic                  U,
    input  logic                  W,
    input  logic [15:0]           regList,
    input  logic [3:0]            baseReg,
    input  logic [DATA_WIDTH-1:0] baseAddr,
    input  logic [DATA_WIDTH-1:0] memDataIn,
    input  logic                  MOC,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] memAddress,
    output logic                  memEnable,
    output logic                  memRW,
    output logic                  rfRW,
    output logic [3:0]            rfWriteAddress,
    output logic [3:0]            rfAddressB,
    output logic [DATA_WIDTH-1:0] rfInputData
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_XFER   = 3'd2,
        S_LOADWR = 3'd3,
        S_WB     = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [DATA_WIDTH-1:0] STEP = DATA_WIDTH'(WORD_BYTES);

    // Number of set bits in a register list.
    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < 16; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

    // Index of the lowest set bit (0 when the list is empty).
    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    state_t                state_q, state_d;
    logic                  l_q, l_d;
    logic                  p_q, p_d;
    logic                  u_q, u_d;
    logic                  wb_en_q, wb_en_d;
    logic                  gap_q, gap_d;
    logic [15:0]           list_q, list_d;
    logic [3:0]            base_reg_q, base_reg_d;
    logic [DATA_WIDTH-1:0] base_q, base_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] final_q, final_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic [4:0]            n_s;
    logic [DATA_WIDTH-1:0] off_s;
    logic [3:0]            cur_s;
    logic [15:0]           cur_mask_s;

    assign n_s        = popcount16(list_q);
    assign off_s      = DATA_WIDTH'(n_s) * STEP;
    assign cur_s      = lowest_set(list_q);
    assign cur_mask_s = 16'd1 << cur_s;

    // Next-state and datapath update for the transfer sequence.
    always_comb begin
        state_d    = state_q;
        l_d        = l_q;
        p_d        = p_q;
        u_d        = u_q;
        wb_en_d    = wb_en_q;
        gap_d      = gap_q;
        list_d     = list_q;
        base_reg_d = base_reg_q;
        base_d     = base_q;
        addr_d     = addr_q;
        final_d    = final_q;
        data_d     = data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    l_d        = L;
                    p_d        = P;
                    u_d        = U;
                    // A loaded base register wins over the writeback.
                    wb_en_d    = W & ~(L & regList[baseReg]);
                    list_d     = regList;
                    base_reg_d = baseReg;
                    base_d     = baseAddr;
                    state_d    = S_SETUP;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_SETUP: begin
                gap_d   = 1'b0;
                final_d = u_q ? (base_q + off_s) : (base_q - off_s);
                case ({p_q, u_q})
                    2'b01:   addr_d = base_q;                 // IA
                    2'b11:   addr_d = base_q + STEP;          // IB
                    2'b00:   addr_d = base_q - off_s + STEP;  // DA
                    2'b10:   addr_d = base_q - off_s;         // DB
                    default: addr_d = base_q;
                endcase
                if (n_s == 5'd0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (gap_q) begin
                    // Strobe-low cycle: decide whether another register follows.
                    if (list_q == 16'd0) begin
                        state_d = wb_en_q ? S_WB : S_DONE;
                    end else begin
                        gap_d   = 1'b0;
                    end
                end else if (MOC) begin
                    if (l_q) begin
                        data_d  = memDataIn;
                        state_d = S_LOADWR;
                    end else begin
                        list_d  = list_q & ~cur_mask_s;
                        addr_d  = addr_q + STEP;
                        gap_d   = 1'b1;
                    end
                end else begin
                    state_d = S_XFER;
                end
            end
            S_LOADWR: begin
                list_d  = list_q & ~cur_mask_s;
                addr_d  = addr_q + STEP;
                gap_d   = 1'b1;
                state_d = S_XFER;
            end
            S_WB: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!CLR) begin
            state_q    <= S_IDLE;
            l_q        <= 1'b0;
            p_q        <= 1'b0;
            u_q        <= 1'b0;
            wb_en_q    <= 1'b0;
            gap_q      <= 1'b0;
            list_q     <= 16'd0;
            base_reg_q <= 4'd0;
            base_q     <= '0;
            addr_q     <= '0;
            final_q    <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            l_q        <= l_d;
            p_q        <= p_d;
            u_q        <= u_d;
            wb_en_q    <= wb_en_d;
            gap_q      <= gap_d;
            list_q     <= list_d;
            base_reg_q <= base_reg_d;
            base_q     <= base_d;
            addr_q     <= addr_d;
            final_q    <= final_d;
            data_q     <= data_d;
        end
    end

    // Output decode from registered state.
    always_comb begin
        busy           = (state_q != S_IDLE);
        done           = (state_q == S_DONE);
        memEnable      = (state_q == S_XFER) && !gap_q;
        memRW          = memEnable & l_q;
        memAddress     = addr_q;
        rfAddressB     = (state_q == S_XFER) ? cur_s : 4'd0;
        rfRW           = 1'b1;
        rfWriteAddress = 4'd0;
        rfInputData    = '0;
        if (state_q == S_LOADWR) begin
            rfRW           = 1'b0;
            rfWriteAddress = cur_s;
            rfInputData    = data_q;
        end else if (state_q == S_WB) begin
            rfRW           = 1'b0;
            rfWriteAddress = base_reg_q;
            rfInputData    = final_q;
        end else begin
            rfRW           = 1'b1;
        end
    end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed testbench for ldm_stm_sequencer with a small memory responder
// (programmable MOC delay, read data = address ^ 0xA5A50000) and a log of
// memory accesses and register-file writes.
module tb_ldm_stm_sequencer;

    logic        CLK = 1'b0;
    logic        CLR;
    logic        start;
    logic        L, P, U, W;
    logic [15:0] regList;
    logic [3:0]  baseReg;
    logic [31:0] baseAddr;
    logic [31:0] memDataIn;
    logic        MOC;
    logic        busy, done, memEnable, memRW, rfRW;
    logic [31:0] memAddress, rfInputData;
    logic [3:0]  rfWriteAddress, rfAddressB;

    ldm_stm_sequencer #(.DATA_WIDTH(32), .WORD_BYTES(4)) dut (
        .CLK(CLK), .CLR(CLR), .start(start), .L(L), .P(P), .U(U), .W(W),
        .regList(regList), .baseReg(baseReg), .baseAddr(baseAddr),
        .memDataIn(memDataIn), .MOC(MOC), .busy(busy), .done(done),
        .memAddress(memAddress), .memEnable(memEnable), .memRW(memRW),
        .rfRW(rfRW), .rfWriteAddress(rfWriteAddress), .rfAddressB(rfAddressB),
        .rfInputData(rfInputData)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Log of observed activity.
    int          moc_delay = 0;
    int          wait_cnt  = 0;
    bit          moc_prev  = 1'b0;
    logic [31:0] held_addr;
    logic        held_rw;
    int          hold_err = 0;
    int          gap_err  = 0;
    int          n_acc = 0;
    int          n_wr  = 0;
    int          n_en  = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic [31:0] acc_addr [16];
    logic        acc_rw   [16];
    logic [3:0]  acc_rb   [16];
    logic [3:0]  wr_addr  [16];
    logic [31:0] wr_data  [16];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Memory responder and activity monitor, on the falling edge.
    always @(negedge CLK) begin
        if (memEnable === 1'b1) begin
            n_en++;
            if (moc_prev) gap_err++;
            if (wait_cnt == 0) begin
                held_addr = memAddress;
                held_rw   = memRW;
            end else if (memAddress !== held_addr || memRW !== held_rw) begin
                hold_err++;
            end
            memDataIn = memAddress ^ 32'hA5A5_0000;
            if (wait_cnt >= moc_delay) begin
                MOC = 1'b1;
                if (n_acc < 16) begin
                    acc_addr[n_acc] = memAddress;
                    acc_rw[n_acc]   = memRW;
                    acc_rb[n_acc]   = rfAddressB;
                end
                n_acc++;
                wait_cnt = 0;
            end else begin
                MOC = 1'b0;
                wait_cnt++;
            end
        end else begin
            MOC = 1'b0;
            wait_cnt = 0;
        end
        moc_prev = MOC;
        if (rfRW === 1'b0) begin
            if (n_wr < 16) begin
                wr_addr[n_wr] = rfWriteAddress;
                wr_data[n_wr] = rfInputData;
            end
            n_wr++;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic clear_log();
        n_acc = 0; n_wr = 0; n_en = 0; done_cnt = 0;
        hold_err = 0; gap_err = 0;
    endtask

    // Run one transfer; returns start-to-done latency in cycles (-1 on timeout).
    task automatic do_op(input logic l, input logic p, input logic u, input logic w,
                         input logic [15:0] list, input logic [3:0] br,
                         input logic [31:0] base, input int dly, input bit poke,
                         output int lat);
        int start_cyc;
        int k;
        moc_delay = dly;
        clear_log();
        @(posedge CLK); #1;
        L = l; P = p; U = u; W = w; regList = list; baseReg = br; baseAddr = base;
        start = 1'b1;
        start_cyc = cyc;
        k = 0;
        lat = -1;
        while (k < 300 && done_cnt == 0) begin
            @(posedge CLK); #1;
            k++;
            if (poke && busy && (k % 3 == 0)) begin
                start = 1'b1; regList = 16'hFFFF; baseAddr = 32'hDEAD_0000;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (done_cnt == 0) begin
            check_eq("timeout", 32'd0, 32'd1);
        end else begin
            lat = done_cyc - start_cyc;
        end
        repeat (4) @(posedge CLK);
        #1;
    endtask

    int lat;

    initial begin
        CLR = 1'b0; start = 1'b0; L = 1'b0; P = 1'b0; U = 1'b0; W = 1'b0;
        regList = 16'd0; baseReg = 4'd0; baseAddr = 32'd0;
        MOC = 1'b0; memDataIn = 32'd0;
        repeat (3) @(posedge CLK);
        #1;
        check_eq("rst_busy",  {31'd0, busy},      32'd0);
        check_eq("rst_done",  {31'd0, done},      32'd0);
        check_eq("rst_memen", {31'd0, memEnable}, 32'd0);
        check_eq("rst_rfrw",  {31'd0, rfRW},      32'd1);
        check_eq("rst_addr",  memAddress,         32'd0);
        check_eq("rst_rfdat", rfInputData,        32'd0);
        CLR = 1'b1;

        // LDMIA R0!,{R1,R2}, base 0x100
        do_op(1'b1, 1'b0, 1'b1, 1'b1, 16'h0006, 4'd0, 32'h0000_0100, 0, 1'b0, lat);
        check_eq("ia_nacc",  n_acc,        32'd2);
        check_eq("ia_a0",    acc_addr[0],  32'h0000_0100);
        check_eq("ia_rw0",   {31'd0, acc_rw[0]}, 32'd1);
        check_eq("ia_a1",    acc_addr[1],  32'h0000_0104);
        check_eq("ia_nwr",   n_wr,         32'd3);
        check_eq("ia_w0a",   {28'd0, wr_addr[0]}, 32'd1);
        check_eq("ia_w0d",   wr_data[0],   32'hA5A5_0100);
        check_eq("ia_w1a",   {28'd0, wr_addr[1]}, 32'd2);
        check_eq("ia_w1d",   wr_data[1],   32'hA5A5_0104);
        check_eq("ia_wba",   {28'd0, wr_addr[2]}, 32'd0);
        check_eq("ia_wbd",   wr_data[2],   32'h0000_0108);
        check_eq("ia_done",  done_cnt,     32'd1);
        check_eq("ia_lat",   lat,          32'd9);
        check_eq("ia_gap",   gap_err,      32'd0);

        // STMDB R13!,{R4,R14}, base 0x1000
        do_op(1'b0, 1'b1, 1'b0, 1'b1, 16'h4010, 4'd13, 32'h0000_1000, 0, 1'b0, lat);
        check_eq("db_nacc",  n_acc,        32'd2);
        check_eq("db_a0",    acc_addr[0],  32'h0000_0FF8);
        check_eq("db_rb0",   {28'd0, acc_rb[0]}, 32'd4);
        check_eq("db_rw0",   {31'd0, acc_rw[0]}, 32'd0);
        check_eq("db_a1",    acc_addr[1],  32'h0000_0FFC);
        check_eq("db_rb1",   {28'd0, acc_rb[1]}, 32'd14);
        check_eq("db_nwr",   n_wr,         32'd1);
        check_eq("db_wba",   {28'd0, wr_addr[0]}, 32'd13);
        check_eq("db_wbd",   wr_data[0],   32'h0000_0FF8);
        check_eq("db_lat",   lat,          32'd7);
        check_eq("db_gap",   gap_err,      32'd0);

        // Empty list with writeback requested
        do_op(1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 4'd2, 32'h0000_0500, 0, 1'b0, lat);
        check_eq("z_lat",    lat,          32'd2);
        check_eq("z_en",     n_en,         32'd0);
        check_eq("z_nwr",    n_wr,         32'd0);
        check_eq("z_done",   done_cnt,     32'd1);

        // LDMIB R3!,{R3,R5}, base 0x200: loaded base wins, no writeback
        do_op(1'b1, 1'b1, 1'b1, 1'b1, 16'h0028, 4'd3, 32'h0000_0200, 0, 1'b0, lat);
        check_eq("ib_a0",    acc_addr[0],  32'h0000_0204);
        check_eq("ib_a1",    acc_addr[1],  32'h0000_0208);
        check_eq("ib_nwr",   n_wr,         32'd2);
        check_eq("ib_w0a",   {28'd0, wr_addr[0]}, 32'd3);
        check_eq("ib_w0d",   wr_data[0],   32'hA5A5_0204);
        check_eq("ib_w1a",   {28'd0, wr_addr[1]}, 32'd5);
        check_eq("ib_lat",   lat,          32'd8);

        // STMIA R2,{R0,R1,R7}, base 0x40, MOC after 3 wait cycles, start pokes
        do_op(1'b0, 1'b0, 1'b1, 1'b0, 16'h0083, 4'd2, 32'h0000_0040, 3, 1'b1, lat);
        check_eq("wt_nacc",  n_acc,        32'd3);
        check_eq("wt_a2",    acc_addr[2],  32'h0000_0048);
        check_eq("wt_rb2",   {28'd0, acc_rb[2]}, 32'd7);
        check_eq("wt_hold",  hold_err,     32'd0);
        check_eq("wt_en",    n_en,         32'd12);
        check_eq("wt_nwr",   n_wr,         32'd0);
        check_eq("wt_lat",   lat,          32'd17);
        check_eq("wt_done",  done_cnt,     32'd1);

        // Reset during the second XFER of a 4-register LDM
        moc_delay = 0;
        clear_log();
        @(posedge CLK); #1;
        L = 1'b1; P = 1'b0; U = 1'b1; W = 1'b1; regList = 16'h001E;
        baseReg = 4'd0; baseAddr = 32'h0000_0300; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (memEnable === 1'b1 && n_acc == 1) break;
            @(posedge CLK); #1;
        end
        check_eq("rs_2nd",   memAddress,   32'h0000_0304);
        CLR = 1'b0;
        @(posedge CLK); #1;
        check_eq("rs_busy",  {31'd0, busy},      32'd0);
        check_eq("rs_memen", {31'd0, memEnable}, 32'd0);
        check_eq("rs_memrw", {31'd0, memRW},     32'd0);
        check_eq("rs_rfrw",  {31'd0, rfRW},      32'd1);
        @(posedge CLK); #1;
        CLR = 1'b1;
        repeat (6) @(posedge CLK);
        #1;
        check_eq("rs_nwr",   n_wr,         32'd1);
        check_eq("rs_done",  done_cnt,     32'd0);
        check_eq("rs_nen",   n_en,         32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
